// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Shared opcode/width constants and decode helpers for the
//               RV32I ALU decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // Shift-immediates keep instr[31:25] as funct7 so SRAI is distinguishable
    function automatic logic is_shift_funct3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage : decode_stage_pkg
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch-side, write-back and execute-side signals of the
//               decode stage, grouped with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       instr;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       operand1;
    logic [XLEN-1:0]       operand2;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
    logic                  illegal;

    modport master (
        output in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, operand1, operand2, funct7, funct3,
               rd, rd_we, illegal
    );

    modport slave (
        input  in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, operand1, operand2, funct7, funct3,
               rd, rd_we, illegal
    );

endinterface : decode_stage_if
`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32x32 register file, two async read ports with write-through
//               bypass, one sync write port, x0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import decode_stage_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  wire logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic      [XLEN-1:0]       o_rs1_data,
    output logic      [XLEN-1:0]       o_rs2_data,
    input  wire logic                  i_we,
    input  wire logic [REG_ADDR_W-1:0] i_wr_addr,
    input  wire logic [XLEN-1:0]       i_wr_data
);

    logic [XLEN-1:0] r_regs [1:31];
    logic [XLEN-1:0] w_regs [0:31];

    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_regs[gi] <= '0;
            end else if (i_we && (i_wr_addr == REG_ADDR_W'(gi))) begin
                r_regs[gi] <= i_wr_data;
            end
        end
    end

    always_comb begin
        w_regs[0] = '0;
        for (int i = 1; i < 32; i++) begin
            w_regs[i] = r_regs[i];
        end
    end

    // A same-cycle write to a nonzero source register is forwarded
    always_comb begin
        o_rs1_data = w_regs[i_rs1_addr];
        o_rs2_data = w_regs[i_rs2_addr];
        if (i_we && (i_wr_addr == i_rs1_addr) && (i_rs1_addr != '0)) begin
            o_rs1_data = i_wr_data;
        end
        if (i_we && (i_wr_addr == i_rs2_addr) && (i_rs2_addr != '0)) begin
            o_rs2_data = i_wr_data;
        end
    end

endmodule : reg_file
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I R-type / I-type ALU decode with a single-entry
//               valid/ready output register and illegal-opcode pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
(
    input wire logic      clk,
    input wire logic      rst_n,
    decode_stage_if.slave bus
);

    logic [6:0]            w_opcode;
    logic                  w_is_r;
    logic                  w_is_i;
    logic                  w_legal;
    logic                  w_in_ready;
    logic                  w_xfer;
    logic                  w_load;
    logic [XLEN-1:0]       w_rs1_data;
    logic [XLEN-1:0]       w_rs2_data;
    logic [XLEN-1:0]       w_op2;
    logic [6:0]            w_funct7;

    logic                  r_out_valid;
    logic                  r_illegal;
    logic [XLEN-1:0]       r_operand1;
    logic [XLEN-1:0]       r_operand2;
    logic [6:0]            r_funct7;
    logic [2:0]            r_funct3;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_rd_we;

    reg_file u_reg_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs1_addr (bus.instr[19:15]),
        .i_rs2_addr (bus.instr[24:20]),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (bus.wb_en),
        .i_wr_addr  (bus.wb_rd),
        .i_wr_data  (bus.wb_data)
    );

    assign w_opcode   = bus.instr[6:0];
    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_i     = (w_opcode == OP_I);
    assign w_legal    = w_is_r || w_is_i;
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_load     = w_xfer && w_legal;

    always_comb begin
        w_op2    = w_rs2_data;
        w_funct7 = bus.instr[31:25];
        if (w_is_i) begin
            w_op2 = sext_imm12(bus.instr[31:20]);
            if (!is_shift_funct3(bus.instr[14:12])) begin
                w_funct7 = '0;
            end
        end
    end

    // Illegal words are consumed but never occupy the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_operand1  <= '0;
            r_operand2  <= '0;
            r_funct7    <= '0;
            r_funct3    <= '0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
        end else begin
            r_illegal <= w_xfer && !w_legal;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_operand1  <= w_rs1_data;
                r_operand2  <= w_op2;
                r_funct7    <= w_funct7;
                r_funct3    <= bus.instr[14:12];
                r_rd        <= bus.instr[11:7];
                r_rd_we     <= (bus.instr[11:7] != '0);
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.illegal   = r_illegal;
    assign bus.operand1  = r_operand1;
    assign bus.operand2  = r_operand2;
    assign bus.funct7    = r_funct7;
    assign bus.funct3    = r_funct3;
    assign bus.rd        = r_rd;
    assign bus.rd_we     = r_rd_we;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_illegal",   32'(bus.illegal),   32'd0);
        check("rst_operand1",  bus.operand1,       32'd0);
        check("rst_operand2",  bus.operand2,       32'd0);
        check("rst_rd_we",     32'(bus.rd_we),     32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Write-back x1=5, x2=3, attempt x0=0x1234
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
        tick();
        bus.wb_rd = 5'd2; bus.wb_data = 32'd3;
        tick();
        bus.wb_rd = 5'd0; bus.wb_data = 32'h0000_1234;
        tick();
        bus.wb_en = 1'b0;

        // add x3,x1,x2
        bus.in_valid = 1'b1; bus.instr = 32'h0020_81B3;
        tick();
        bus.in_valid = 1'b0;
        check("add_out_valid", 32'(bus.out_valid), 32'd1);
        check("add_operand1",  bus.operand1,       32'd5);
        check("add_operand2",  bus.operand2,       32'd3);
        check("add_funct7",    32'(bus.funct7),    32'd0);
        check("add_funct3",    32'(bus.funct3),    32'd0);
        check("add_rd",        32'(bus.rd),        32'd3);
        check("add_rd_we",     32'(bus.rd_we),     32'd1);
        tick();
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);

        // addi x4,x0,-1 (x0 must still read zero)
        bus.in_valid = 1'b1; bus.instr = 32'hFFF0_0213;
        tick();
        check("addi_operand1", bus.operand1,       32'd0);
        check("addi_operand2", bus.operand2,       32'hFFFF_FFFF);
        check("addi_funct7",   32'(bus.funct7),    32'd0);
        check("addi_rd",       32'(bus.rd),        32'd4);
        check("addi_rd_we",    32'(bus.rd_we),     32'd1);

        // srai x5,x1,2 back-to-back
        bus.instr = 32'h4020_D293;
        tick();
        check("srai_operand1", bus.operand1,       32'd5);
        check("srai_operand2", bus.operand2,       32'h0000_0402);
        check("srai_funct7",   32'(bus.funct7),    32'h20);
        check("srai_funct3",   32'(bus.funct3),    32'd5);
        check("srai_rd",       32'(bus.rd),        32'd5);

        // addi x0,x0,1 -> rd_we cleared
        bus.instr = 32'h0010_0013;
        tick();
        check("rd0_rd_we",     32'(bus.rd_we),     32'd0);
        check("rd0_operand2",  bus.operand2,       32'd1);

        // add with same-cycle write-back to x1
        bus.instr = 32'h0020_81B3;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hDEAD_BEEF;
        tick();
        bus.wb_en = 1'b0;
        bus.in_valid = 1'b0;
        check("byp_operand1",  bus.operand1,       32'hDEAD_BEEF);
        check("byp_operand2",  bus.operand2,       32'd3);
        tick();

        // Stall: out_ready low for 3 cycles with in_valid held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.instr = 32'h0020_81B3;
        tick();
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        bus.instr = 32'hFFF0_0213;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
            check("stall_operand1", bus.operand1,      32'hDEAD_BEEF);
            check("stall_rd",       32'(bus.rd),       32'd3);
        end
        bus.out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("unstall_out_valid", 32'(bus.out_valid), 32'd1);
        check("unstall_rd",        32'(bus.rd),        32'd4);
        check("unstall_operand2",  bus.operand2,       32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        tick();
        check("unstall_drain", 32'(bus.out_valid), 32'd0);

        // Illegal opcode
        bus.in_valid = 1'b1; bus.instr = 32'h0000_007F;
        tick();
        bus.in_valid = 1'b0;
        check("ill_pulse",     32'(bus.illegal),   32'd1);
        check("ill_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("ill_pulse_end", 32'(bus.illegal),   32'd0);

        // Reset asserted mid-stall
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.instr = 32'h0020_81B3;
        tick();
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_operand1",  bus.operand1,       32'd0);
        check("mid_rst_funct3",    32'(bus.funct3),    32'd0);
        check("mid_rst_rd",        32'(bus.rd),        32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // First post-reset decode; registers were cleared
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_operand1",  bus.operand1,       32'd0);
        check("post_rst_operand2",  bus.operand2,       32'd0);
        check("post_rst_rd",        32'(bus.rd),        32'd3);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire
